// File: rtl/nap_countdown_if.sv
// ============================================================================
// Module      : nap_countdown_if
// Description : Setting-stage inputs and display/buzzer outputs of the nap
//               countdown.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nap_countdown_if;
    logic       load;
    logic       pause;
    logic       stop;
    logic [3:0] hour_ten_in;
    logic [3:0] hour_one_in;
    logic [3:0] min_ten_in;
    logic [3:0] min_one_in;
    logic [3:0] sec_ten_in;
    logic [3:0] sec_one_in;
    logic [3:0] hour_ten_out;
    logic [3:0] hour_one_out;
    logic [3:0] min_ten_out;
    logic [3:0] min_one_out;
    logic [3:0] sec_ten_out;
    logic [3:0] sec_one_out;
    logic       running;
    logic       paused;
    logic       alarm;

    modport master (
        output load, pause, stop,
        output hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
        input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
        input  running, paused, alarm
    );

    modport slave (
        input  load, pause, stop,
        input  hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
        output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
        output running, paused, alarm
    );
endinterface

`default_nettype wire

// File: rtl/nap_countdown.sv
// ============================================================================
// Module      : nap_countdown
// Description : BCD hh:mm:ss countdown with pause/stop and timed wake alarm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nap_countdown #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int ALARM_SECS    = 10
) (
    input  logic            clk,
    input  logic            rst,
    nap_countdown_if.slave  bus
);

    localparam int c_PRESC_W = $clog2(TICKS_PER_SEC);
    localparam int c_ACNT_W  = $clog2(ALARM_SECS + 1);
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [c_ACNT_W-1:0]  c_ACNT_LAST = c_ACNT_W'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    // Digit index 5 = hour_ten ... 0 = sec_one
    state_t                  r_state, w_state_nxt;
    logic [5:0][3:0]         r_dig, w_dig_nxt, w_dec, w_in;
    logic [c_PRESC_W-1:0]    r_presc, w_presc_nxt;
    logic [c_ACNT_W-1:0]     r_acnt, w_acnt_nxt;
    logic                    w_load_ok, w_tick, w_borrow, w_dec_zero;

    assign w_in = {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
                   bus.min_one_in, bus.sec_ten_in, bus.sec_one_in};

    assign w_load_ok = (w_in[5] <= 4'd9) && (w_in[4] <= 4'd9) &&
                       (w_in[3] <= 4'd5) && (w_in[2] <= 4'd9) &&
                       (w_in[1] <= 4'd5) && (w_in[0] <= 4'd9) &&
                       (w_in != '0);

    assign w_tick = (r_presc == c_TICK_LAST);

    // Ripple-borrow BCD decrement; tens of minutes/seconds wrap to 5
    always_comb begin
        w_dec    = r_dig;
        w_borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_borrow) begin
                if (r_dig[i] == 4'd0 && i < 5) begin
                    w_dec[i] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    w_dec[i] = r_dig[i] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
    end

    assign w_dec_zero = (w_dec == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_presc_nxt = r_presc;
        w_acnt_nxt  = r_acnt;
        case (r_state)
            S_IDLE: begin
                if (!bus.stop && bus.load && w_load_ok) begin
                    w_state_nxt = S_RUN;
                    w_dig_nxt   = w_in;
                    w_presc_nxt = '0;
                end
            end
            S_RUN, S_PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                end else if (bus.load && w_load_ok) begin
                    w_state_nxt = S_RUN;
                    w_dig_nxt   = w_in;
                    w_presc_nxt = '0;
                end else if (bus.pause) begin
                    w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
                end else if (r_state == S_RUN) begin
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        w_dig_nxt   = w_dec;
                        if (w_dec_zero) begin
                            w_state_nxt = S_ALARM;
                            w_acnt_nxt  = '0;
                        end
                    end else begin
                        w_presc_nxt = r_presc + c_PRESC_W'(1);
                    end
                end
            end
            S_ALARM: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    w_acnt_nxt  = r_acnt + c_ACNT_W'(1);
                    if (r_acnt == c_ACNT_LAST) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_presc_nxt = r_presc + c_PRESC_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_dig   <= '0;
            r_presc <= '0;
            r_acnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_dig_nxt;
            r_presc <= w_presc_nxt;
            r_acnt  <= w_acnt_nxt;
        end
    end

    assign bus.hour_ten_out = r_dig[5];
    assign bus.hour_one_out = r_dig[4];
    assign bus.min_ten_out  = r_dig[3];
    assign bus.min_one_out  = r_dig[2];
    assign bus.sec_ten_out  = r_dig[1];
    assign bus.sec_one_out  = r_dig[0];
    assign bus.running      = (r_state == S_RUN);
    assign bus.paused       = (r_state == S_PAUSE);
    assign bus.alarm        = (r_state == S_ALARM);

endmodule

`default_nettype wire

// File: tb/tb_nap_countdown.sv
// ============================================================================
// Module      : tb_nap_countdown
// Description : Directed bench for nap_countdown against a seconds-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nap_countdown;

    localparam int T = 4;
    localparam int A = 2;
    localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_PAUSE = 2'd2, M_ALARM = 2'd3;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] secs;
        logic [31:0] phase;
        logic [31:0] acnt;
    } model_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   chk_en = 1'b0;
    int     total = 0;
    int     bad = 0;
    model_t m = '0;

    nap_countdown_if bus ();

    nap_countdown #(.TICKS_PER_SEC(T), .ALARM_SECS(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] dig();
        return {bus.hour_ten_out, bus.hour_one_out, bus.min_ten_out,
                bus.min_one_out, bus.sec_ten_out, bus.sec_one_out};
    endfunction

    function automatic logic [2:0] stat();
        return {bus.running, bus.paused, bus.alarm};
    endfunction

    function automatic logic [23:0] to_bcd(int s);
        int h, mn, sc;
        h  = s / 3600;
        mn = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    // Remaining time kept as a plain number of seconds plus a cycle phase
    function automatic model_t model_next(model_t cur, logic ld, logic ps, logic sp, logic [23:0] d);
        model_t n;
        int     v;
        logic   ok;
        n  = cur;
        v  = (int'(d[23:20]) * 10 + int'(d[19:16])) * 3600 +
             (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 +
             int'(d[7:4]) * 10 + int'(d[3:0]);
        ok = ld && d[23:20] <= 9 && d[19:16] <= 9 && d[15:12] <= 5 &&
             d[11:8] <= 9 && d[7:4] <= 5 && d[3:0] <= 9 && v > 0;
        if (cur.mode == M_IDLE) begin
            if (!sp && ok) begin
                n.mode = M_RUN; n.secs = v; n.phase = 0;
            end
        end else if (cur.mode == M_ALARM) begin
            if (sp) begin
                n.mode = M_IDLE; n.phase = 0;
            end else if (cur.phase == T - 1) begin
                n.phase = 0;
                n.acnt  = cur.acnt + 1;
                if (cur.acnt + 1 == A) n.mode = M_IDLE;
            end else begin
                n.phase = cur.phase + 1;
            end
        end else begin
            if (sp) begin
                n.mode = M_IDLE; n.phase = 0;
            end else if (ok) begin
                n.mode = M_RUN; n.secs = v; n.phase = 0;
            end else if (ps) begin
                n.mode = (cur.mode == M_RUN) ? M_PAUSE : M_RUN;
            end else if (cur.mode == M_RUN) begin
                if (cur.phase == T - 1) begin
                    n.phase = 0;
                    n.secs  = cur.secs - 1;
                    if (cur.secs == 1) begin
                        n.mode = M_ALARM; n.acnt = 0;
                    end
                end else begin
                    n.phase = cur.phase + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else m <= model_next(m, bus.load, bus.pause, bus.stop,
                             {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
                              bus.min_one_in, bus.sec_ten_in, bus.sec_one_in});
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle", {5'd0, dig(), stat()},
                {5'd0, to_bcd(int'(m.secs)), m.mode == M_RUN, m.mode == M_PAUSE, m.mode == M_ALARM});
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(logic [23:0] d, logic with_stop);
        {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
         bus.min_one_in, bus.sec_ten_in, bus.sec_one_in} = d;
        bus.load = 1'b1;
        bus.stop = with_stop;
        step(1);
        bus.load = 1'b0;
        bus.stop = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.pause = 1'b1;
        step(1);
        bus.pause = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
        {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
         bus.min_one_in, bus.sec_ten_in, bus.sec_one_in} = '0;
        #3 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_dig", 32'(dig()), 32'h0);
        chk("rst_stat", 32'(stat()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);

        pulse_pause();
        chk("idle_pause", 32'(stat()), 32'h0);

        // Full countdown of 3 s into a 2 s alarm
        pulse_load(24'h000003, 1'b0);
        chk("t1_run", 32'(stat()), 32'h4);
        chk("t1_load", 32'(dig()), 32'h000003);
        step(4); chk("t1_2", 32'(dig()), 32'h000002);
        step(4); chk("t1_1", 32'(dig()), 32'h000001);
        step(4); chk("t1_alarm", 32'(stat()), 32'h1);
        chk("t1_zero", 32'(dig()), 32'h0);
        step(7); chk("t1_alarm_hold", 32'(stat()), 32'h1);
        step(1); chk("t1_idle", 32'(stat()), 32'h0);
        chk("t1_idle_dig", 32'(dig()), 32'h0);

        // Borrow chains
        pulse_load(24'h010000, 1'b0); step(4);
        chk("b_hour", 32'(dig()), 32'h005959);
        pulse_load(24'h100000, 1'b0); step(4);
        chk("b_hten", 32'(dig()), 32'h095959);
        pulse_load(24'h001000, 1'b0); step(4);
        chk("b_mten", 32'(dig()), 32'h000959);
        pulse_stop();
        chk("stop_stat", 32'(stat()), 32'h0);
        chk("stop_dig", 32'(dig()), 32'h000959);

        // Pause keeps partial-second progress
        pulse_load(24'h000005, 1'b0);
        step(4); chk("p_4", 32'(dig()), 32'h000004);
        step(2);
        pulse_pause();
        chk("p_paused", 32'(stat()), 32'h2);
        step(20);
        chk("p_frozen", 32'(dig()), 32'h000004);
        pulse_pause();
        chk("p_resume", 32'(stat()), 32'h4);
        step(1); chk("p_still4", 32'(dig()), 32'h000004);
        step(1); chk("p_3", 32'(dig()), 32'h000003);

        // Invalid loads in IDLE
        pulse_stop();
        chk("s_dig", 32'(dig()), 32'h000003);
        pulse_load(24'h006000, 1'b0);
        chk("inv_min", {29'd0, stat()} | {8'd0, dig()}, 32'h000003);
        pulse_load(24'h00000A, 1'b0);
        chk("inv_bcd", {29'd0, stat()} | {8'd0, dig()}, 32'h000003);
        pulse_load(24'h000000, 1'b0);
        chk("inv_zero", {29'd0, stat()} | {8'd0, dig()}, 32'h000003);

        // Reload mid-run restarts with a fresh prescaler
        pulse_load(24'h000002, 1'b0);
        step(4); chk("r_1", 32'(dig()), 32'h000001);
        pulse_load(24'h000002, 1'b0);
        chk("r_reload", 32'(dig()), 32'h000002);
        step(3); chk("r_hold", 32'(dig()), 32'h000002);
        step(1); chk("r_dec", 32'(dig()), 32'h000001);

        // stop beats load; stop silences alarm
        pulse_load(24'h000007, 1'b1);
        chk("sl_stat", 32'(stat()), 32'h0);
        chk("sl_dig", 32'(dig()), 32'h000001);
        pulse_load(24'h000001, 1'b0);
        step(4); chk("a_on", 32'(stat()), 32'h1);
        pulse_stop();
        chk("a_off", 32'(stat()), 32'h0);

        // Asynchronous reset between edges
        pulse_load(24'h000003, 1'b0);
        step(4); chk("ar_pre", 32'(dig()), 32'h000002);
        #2 rst = 1'b0;
        #1;
        chk("ar_dig", 32'(dig()), 32'h0);
        chk("ar_stat", 32'(stat()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(5);
        chk("ar_after", {29'd0, stat()} | {8'd0, dig()}, 32'h0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
